active_list_retire: RTL
=======================

// Module: active_list_retire
// PURPOSE
//  In-order active list (ROB) for the rename stage: the release side of physical-register renaming.
//  Rename pushes one entry per renamed instruction: arch dest, new preg, previous preg.
//  Execute marks entries complete by index.
//  Entries retire in order; the superseded (old) preg returns to the free list and the committed mapping goes to the arch map.
//  On flush, entries are walked youngest->oldest to return new pregs and restore the RMT.
// PARAMETERS
//  DEPTH   32              active-list entries (power of 2)
//  AREG_W  5               architectural register index width
//  PREG_W  6               physical register index width
//  IDX_W   $clog2(DEPTH)   entry index width
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  alloc_valid    in   1       rename presents entry
//  alloc_ready    out  1       entry accepted when valid&ready
//  alloc_writes   in   1       instruction writes a dest reg
//  alloc_areg     in   AREG_W  arch dest
//  alloc_new_preg in   PREG_W  newly mapped preg
//  alloc_old_preg in   PREG_W  preg previously mapped to areg
//  alloc_idx      out  IDX_W   index given to accepted entry (=tail)
//  done_valid     in   1       execute completion strobe
//  done_idx       in   IDX_W   completed entry index
//  flush_req      in   1       squash all in-flight entries
//  free_valid     out  1       preg returned to free list
//  free_preg      out  PREG_W  returned preg
//  free_ready     in   1       free list accepts (backpressure)
//  commit_valid   out  1       arch map update (retire)
//  commit_areg    out  AREG_W
//  commit_preg    out  PREG_W  new preg now architectural
//  restore_valid  out  1       RMT rollback write (areg <- old_preg)
//  restore_areg   out  AREG_W
//  restore_preg   out  PREG_W
//  rollback_done  out  1       1-cycle pulse: flush finished
//  count          out  IDX_W+1 occupied entries
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, all entry valid/done cleared, state IDLE.
//    All outputs 0 except alloc_ready=1.
//  - States IDLE, ROLLBACK. All outputs combinational from registered state plus free_ready.
//  - alloc_ready = (state==IDLE) & (count<DEPTH) & !flush_req.
//    No full-bypass: a retire in the same cycle does not free a slot for that cycle's alloc.
//  - Alloc: entry written at tail with done=0; tail+1 mod DEPTH (wraps).
//  - done_valid sets done[done_idx] only if that entry is valid; otherwise ignored.
//    The earliest retire is the cycle after done.
//  - Retire (IDLE, !flush_req, head valid & done):
//    - writes=1: requires free_ready. free_valid=1, free_preg=old_preg, commit_valid=1, commit_areg/commit_preg=areg/new_preg.
//    - writes=0: retires without free_ready; free_valid=0, commit_valid=0.
//    - Effect: head+1, entry invalidated. One retire per cycle max. Alloc and retire in the same cycle leave count unchanged.
//  - flush_req in IDLE, count>0: next state ROLLBACK.
//    - Same-cycle alloc and retire are suppressed.
//    - Done strobes are still recorded but are irrelevant.
//  - ROLLBACK, each cycle on youngest entry e=tail-1:
//    - writes=1: requires free_ready. free_valid=1, free_preg=new_preg, restore_valid=1, restore_areg/restore_preg=areg/old_preg.
//    - writes=0: pops unconditionally.
//    - On pop: tail-1 (wraps 0->DEPTH-1), count-1.
//    - When the last entry pops: rollback_done=1 that same cycle, next state IDLE.
//  - flush_req in IDLE with count==0: rollback_done pulses next cycle; state stays IDLE.
//  - flush_req during ROLLBACK is ignored.
//  - free_ready low stalls retire/rollback with outputs held stable (valid stays high, data unchanged).
//  - rst mid-ROLLBACK: immediate return to reset state; no further free/restore emitted.
// TESTING
//  1. Reset, then alloc 3 entries (w=1; new 33,34,35; old 1,2,3).
//     -> alloc_idx 0,1,2; count=3.
//     Then done idx 2,0,1 -> retires occur in order 0,1,2; free_preg 1,2,3; commit_preg 33,34,35.
//  2. Fill 32 entries -> alloc_ready=0 at count=32. done idx 0 -> retire, then alloc accepted at idx 0 (wrap).
//  3. Alloc 4 entries (areg 5,6,7,8; new 40..43; old 10..13), flush_req.
//     -> restore (8,13),(7,12),(6,11),(5,10) on consecutive cycles; free_preg 43,42,41,40.
//     -> rollback_done with the 4th; count=0; alloc_ready=1 next cycle.
//  4. Retiring head with free_ready=0 for 3 cycles -> free_valid/commit_valid held, head unchanged; retires the cycle free_ready=1.
//  5. Mix writes=0 entries: alloc w=0,w=1 both done.
//     -> w=0 retires with free_valid=0 even when free_ready=0; flush_req on an empty list -> rollback_done a single pulse.
//  6. rst asserted mid-ROLLBACK with 2 entries left -> next cycle count=0, all valids 0, IDLE, no restore_valid.

Source files
------------

// File: rtl/active_list_retire.sv
// In-order active list: allocates renamed entries, retires them in order to the arch map and
// free list, and on flush walks youngest->oldest to release new pregs and roll back the RMT.
module active_list_retire #(
  parameter int DEPTH  = 32,
  parameter int AREG_W = 5,
  parameter int PREG_W = 6,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_writes,
  input  logic [AREG_W-1:0] alloc_areg,
  input  logic [PREG_W-1:0] alloc_new_preg,
  input  logic [PREG_W-1:0] alloc_old_preg,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              done_valid,
  input  logic [IDX_W-1:0]  done_idx,
  input  logic              flush_req,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_preg,
  input  logic              free_ready,
  output logic              commit_valid,
  output logic [AREG_W-1:0] commit_areg,
  output logic [PREG_W-1:0] commit_preg,
  output logic              restore_valid,
  output logic [AREG_W-1:0] restore_areg,
  output logic [PREG_W-1:0] restore_preg,
  output logic              rollback_done,
  output logic [IDX_W:0]    count
);

  typedef enum logic [0:0] {IDLE = 1'b0, ROLLBACK = 1'b1} state_e;

  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   CNT_ZERO = {(IDX_W+1){1'b0}};
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   head_q, head_d, tail_q, tail_d, youngest_s;
  logic [IDX_W:0]     count_q, count_d;
  logic               flush_empty_q;
  logic [DEPTH-1:0]   valid_q, done_q, writes_q;
  logic [AREG_W-1:0]  areg_q [DEPTH];
  logic [PREG_W-1:0]  new_q  [DEPTH];
  logic [PREG_W-1:0]  old_q  [DEPTH];
  logic               alloc_fire_s, head_ready_s, retire_fire_s, pop_s;

  assign youngest_s = tail_q - IDX_ONE;
  assign alloc_idx  = tail_q;
  assign count      = count_q;

  // Handshakes and pointer/occupancy next-state
  always_comb begin
    alloc_ready   = (state_q == IDLE) && (count_q < CNT_FULL) && !flush_req;
    alloc_fire_s  = alloc_valid && alloc_ready;
    head_ready_s  = (state_q == IDLE) && valid_q[head_q] && done_q[head_q] && !flush_req;
    retire_fire_s = head_ready_s && (!writes_q[head_q] || free_ready);
    pop_s         = (state_q == ROLLBACK) && (!writes_q[youngest_s] || free_ready);
    head_d        = retire_fire_s ? head_q + IDX_ONE : head_q;
    if (alloc_fire_s) begin
      tail_d = tail_q + IDX_ONE;
    end else if (pop_s) begin
      tail_d = tail_q - IDX_ONE;
    end else begin
      tail_d = tail_q;
    end
    if (alloc_fire_s && !retire_fire_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!alloc_fire_s && (retire_fire_s || pop_s)) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush_req && (count_q != CNT_ZERO)) state_d = ROLLBACK;
        else                                    state_d = IDLE;
      end
      ROLLBACK: begin
        if (pop_s && (count_q == CNT_ONE)) state_d = IDLE;
        else                               state_d = ROLLBACK;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; data is zeroed whenever its valid is low
  always_comb begin
    free_valid    = 1'b0;
    free_preg     = {PREG_W{1'b0}};
    commit_valid  = 1'b0;
    commit_areg   = {AREG_W{1'b0}};
    commit_preg   = {PREG_W{1'b0}};
    restore_valid = 1'b0;
    restore_areg  = {AREG_W{1'b0}};
    restore_preg  = {PREG_W{1'b0}};
    rollback_done = 1'b0;
    case (state_q)
      IDLE: begin
        rollback_done = flush_empty_q;
        if (head_ready_s && writes_q[head_q]) begin
          free_valid   = 1'b1;
          free_preg    = old_q[head_q];
          commit_valid = 1'b1;
          commit_areg  = areg_q[head_q];
          commit_preg  = new_q[head_q];
        end else begin
          free_valid   = 1'b0;
          commit_valid = 1'b0;
        end
      end
      ROLLBACK: begin
        rollback_done = pop_s && (count_q == CNT_ONE);
        if (writes_q[youngest_s]) begin
          free_valid    = 1'b1;
          free_preg     = new_q[youngest_s];
          restore_valid = 1'b1;
          restore_areg  = areg_q[youngest_s];
          restore_preg  = old_q[youngest_s];
        end else begin
          free_valid    = 1'b0;
          restore_valid = 1'b0;
        end
      end
      default: rollback_done = 1'b0;
    endcase
  end

  // Control state, pointers and per-entry valid/done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      head_q        <= {IDX_W{1'b0}};
      tail_q        <= {IDX_W{1'b0}};
      count_q       <= CNT_ZERO;
      flush_empty_q <= 1'b0;
      valid_q       <= {DEPTH{1'b0}};
      done_q        <= {DEPTH{1'b0}};
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      flush_empty_q <= (state_q == IDLE) && flush_req && (count_q == CNT_ZERO);
      if (done_valid && valid_q[done_idx]) done_q[done_idx] <= 1'b1;
      if (alloc_fire_s) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
      end
      if (retire_fire_s) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
      end
      if (pop_s) begin
        valid_q[youngest_s] <= 1'b0;
        done_q[youngest_s]  <= 1'b0;
      end
    end
  end

  // Entry payload, only meaningful while the entry is valid
  always_ff @(posedge clk) begin
    if (alloc_fire_s) begin
      writes_q[tail_q] <= alloc_writes;
      areg_q[tail_q]   <= alloc_areg;
      new_q[tail_q]    <= alloc_new_preg;
      old_q[tail_q]    <= alloc_old_preg;
    end
  end

endmodule
